// File: rtl/sc_ed_ctrl_if.sv
// Pixel-window and result handshake bundle for the stochastic edge-detector sequencer.
// master = window producer / result consumer, slave = sc_ed_ctrl.
interface sc_ed_ctrl_if #(
    parameter int W    = 8,
    parameter int NPIX = 20
);
    logic              px_valid;
    logic              px_ready;
    logic [NPIX*W-1:0] px_data;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_data;

    modport master (
        output px_valid, px_data, res_ready,
        input  px_ready, res_valid, res_data
    );

    modport slave (
        input  px_valid, px_data, res_ready,
        output px_ready, res_valid, res_data
    );
endinterface

// File: rtl/sc_ed_ctrl.sv
// Job sequencer for the stochastic-computing edge detector: turns one pixel window into
// correlated unipolar bitstreams, then counts ones on the returned stream over one LFSR period.
module sc_ed_ctrl #(
    parameter int           W        = 8,
    parameter int           NPIX     = 20,
    parameter int           PIPE_DLY = 0,
    parameter logic [W-1:0] TAPS     = 8'hB8,
    parameter logic [W-1:0] SEED_X   = 8'h01,
    parameter logic [W-1:0] SEED_C   = 8'h5A
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           abort,
    sc_ed_ctrl_if.slave    bus,
    output logic [NPIX:0]  sc_x,
    output logic           dp_clr,
    input  logic           sc_z,
    output logic           busy
);

    localparam logic [W-1:0] LAST_PHASE = W'((1 << W) - 2);
    localparam logic [W-1:0] HALF       = W'(1 << (W - 1));
    localparam int           DW         = (PIPE_DLY > 1) ? $clog2(PIPE_DLY) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((PIPE_DLY > 0) ? PIPE_DLY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [NPIX*W-1:0] pix;
    logic [W-1:0]      lfsr_x;
    logic [W-1:0]      lfsr_c;
    logic [W-1:0]      phase;
    logic [DW-1:0]     dcnt;
    logic [W-1:0]      count;
    logic              run_cnt_en;

    // Right-shifting Galois step; TAPS must be a maximal-length mask so a full period hits 1..LEN.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    // The first PIPE_DLY RUN samples of sc_z still belong to the previous (cleared) datapath contents.
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign run_cnt_en = 1'b1;
        end else begin : g_dly
            assign run_cnt_en = ({1'b0, phase} >= (W+1)'(PIPE_DLY));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        sc_x          = '0;
        dp_clr        = 1'b0;
        busy          = (state != IDLE);
        bus.px_ready  = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;

        case (state)
            IDLE: begin
                bus.px_ready = 1'b1;
                if (bus.px_valid) begin
                    next_state = CLR;
                end
            end
            CLR: begin
                dp_clr     = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                for (int i = 0; i < NPIX; i++) begin
                    sc_x[i+1] = (lfsr_x <= pix[W*i +: W]);
                end
                sc_x[0] = (lfsr_c < HALF);
                if (phase == LAST_PHASE) begin
                    next_state = (PIPE_DLY == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (dcnt == DRAIN_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                bus.res_data  = count;
                if (bus.res_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (abort && (state != IDLE)) begin
            next_state = IDLE;
        end
    end

    // Window capture, LFSR stepping, phase/drain counters and the ones counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix    <= '0;
            lfsr_x <= SEED_X;
            lfsr_c <= SEED_C;
            phase  <= '0;
            dcnt   <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.px_valid) begin
                        pix    <= bus.px_data;
                        lfsr_x <= SEED_X;
                        lfsr_c <= SEED_C;
                        phase  <= '0;
                        dcnt   <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    lfsr_x <= lfsr_step(lfsr_x);
                    lfsr_c <= lfsr_step(lfsr_c);
                    phase  <= phase + 1'b1;
                    if (run_cnt_en) begin
                        count <= count + {{(W-1){1'b0}}, sc_z};
                    end
                end
                DRAIN: begin
                    dcnt  <= dcnt + 1'b1;
                    count <= count + {{(W-1){1'b0}}, sc_z};
                end
                default: begin
                end
            endcase

            if (abort && (state != IDLE)) begin
                count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sc_ed_ctrl.sv
// Directed bench for sc_ed_ctrl: one instance with no datapath delay and one with a
// 3-cycle delayed stub, each fed back its own pixel-0 stream.
module tb_sc_ed_ctrl;

    localparam int W    = 8;
    localparam int NPIX = 20;
    localparam int LEN  = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              sel;
    logic              drv_valid;
    logic              drv_ready;
    logic              drv_abort;
    logic [NPIX*W-1:0] drv_data;

    int vectors     = 0;
    int miscompares = 0;

    sc_ed_ctrl_if #(.W(W), .NPIX(NPIX)) bus0 ();
    sc_ed_ctrl_if #(.W(W), .NPIX(NPIX)) bus3 ();

    logic [NPIX:0] sc_x0, sc_x3;
    logic          dp_clr0, dp_clr3, busy0, busy3, abort0, abort3, sc_z0, sc_z3;
    logic [2:0]    dly3;

    assign bus0.px_valid  = drv_valid & ~sel;
    assign bus3.px_valid  = drv_valid & sel;
    assign bus0.px_data   = drv_data;
    assign bus3.px_data   = drv_data;
    assign bus0.res_ready = drv_ready & ~sel;
    assign bus3.res_ready = drv_ready & sel;
    assign abort0         = drv_abort & ~sel;
    assign abort3         = drv_abort & sel;

    // Stub datapaths: z = sc_x[1], directly or through three register stages.
    assign sc_z0 = sc_x0[1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly3 <= '0;
        else        dly3 <= {dly3[1:0], sc_x3[1]};
    end
    assign sc_z3 = dly3[2];

    sc_ed_ctrl #(.W(W), .NPIX(NPIX), .PIPE_DLY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .abort(abort0), .bus(bus0.slave),
        .sc_x(sc_x0), .dp_clr(dp_clr0), .sc_z(sc_z0), .busy(busy0)
    );

    sc_ed_ctrl #(.W(W), .NPIX(NPIX), .PIPE_DLY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .abort(abort3), .bus(bus3.slave),
        .sc_x(sc_x3), .dp_clr(dp_clr3), .sc_z(sc_z3), .busy(busy3)
    );

    logic          cur_px_ready, cur_res_valid, cur_dp_clr, cur_busy;
    logic [W-1:0]  cur_res_data;
    logic [NPIX:0] cur_sc_x;
    assign cur_px_ready  = sel ? bus3.px_ready  : bus0.px_ready;
    assign cur_res_valid = sel ? bus3.res_valid : bus0.res_valid;
    assign cur_res_data  = sel ? bus3.res_data  : bus0.res_data;
    assign cur_dp_clr    = sel ? dp_clr3 : dp_clr0;
    assign cur_busy      = sel ? busy3   : busy0;
    assign cur_sc_x      = sel ? sc_x3   : sc_x0;

    // Observations of the most recent job, cycle 1 being the cycle after acceptance.
    int           obs_cyc;
    int           obs_ones [0:NPIX];
    int           obs_clr;
    bit           obs_clr_first;
    int           obs_bad;
    int           obs_busy_low;
    logic [W-1:0] obs_res;
    int           obs_wait;

    function automatic logic [NPIX*W-1:0] make_window(input logic [W-1:0] p0);
        logic [NPIX*W-1:0] v;
        v            = '0;
        v[W-1:0]     = p0;
        v[2*W +: W]  = 8'hFF;
        for (int i = 3; i < NPIX; i++) v[W*i +: W] = W'((i * 37 + 11) % 256);
        return v;
    endfunction

    task automatic start_job(input logic [NPIX*W-1:0] win, input bit with_abort);
        drv_data  = win;
        drv_valid = 1'b1;
        drv_abort = with_abort;
        obs_wait  = 0;
        while (!cur_px_ready && obs_wait < 600) begin
            @(negedge clk);
            obs_wait++;
        end
        @(negedge clk);
        drv_valid = 1'b0;
        drv_abort = 1'b0;
    endtask

    task automatic run_to_result();
        int cyc;
        cyc           = 1;
        obs_cyc       = 0;
        obs_clr       = 0;
        obs_clr_first = 1'b0;
        obs_bad       = 0;
        obs_busy_low  = 0;
        obs_res       = '0;
        for (int i = 0; i <= NPIX; i++) obs_ones[i] = 0;
        while (cyc <= LEN + 40) begin
            if (cur_res_valid) begin
                obs_cyc = cyc;
                obs_res = cur_res_data;
                break;
            end
            if (cur_dp_clr) begin
                obs_clr++;
                if (cyc == 1) obs_clr_first = 1'b1;
            end
            for (int i = 0; i <= NPIX; i++) if (cur_sc_x[i]) obs_ones[i]++;
            if ((cyc == 1 || cyc > LEN + 1) && cur_sc_x != '0) obs_bad++;
            if (!cur_busy) obs_busy_low++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic handshake();
        drv_ready = 1'b1;
        @(negedge clk);
        drv_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (bus0.px_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_px_ready: got %b want 1", bus0.px_ready); end
        vectors++; if (bus0.res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_res_valid: got %b want 0", bus0.res_valid); end
        vectors++; if (bus0.res_data !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_res_data: got %0d want 0", bus0.res_data); end
        vectors++; if (dp_clr0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dp_clr: got %b want 0", dp_clr0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy0); end
        vectors++; if (sc_x0 !== '0) begin miscompares++; $display("[TB] FAIL reset_sc_x: got %h want 0", sc_x0); end
        vectors++; if (bus3.px_ready !== 1'b1 || busy3 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dut3: px_ready %b busy %b want 1/0", bus3.px_ready, busy3); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_stream();
        logic [NPIX*W-1:0] win;
        sel = 1'b0;
        @(negedge clk);
        win = make_window(8'd100);
        start_job(win, 1'b0);
        run_to_result();
        vectors++; if (obs_cyc != LEN + 2) begin miscompares++; $display("[TB] FAIL basic_latency: res_valid seen at edge e0+%0d want e0+%0d", obs_cyc, LEN + 2); end
        vectors++; if (obs_res !== 8'd100) begin miscompares++; $display("[TB] FAIL basic_res: got %0d want 100", obs_res); end
        vectors++; if (obs_ones[0] != 127) begin miscompares++; $display("[TB] FAIL basic_select_ones: got %0d want 127", obs_ones[0]); end
        for (int i = 0; i < NPIX; i++) begin
            vectors++;
            if (obs_ones[i+1] != int'(win[W*i +: W])) begin
                miscompares++;
                $display("[TB] FAIL basic_ones_sc_x[%0d]: got %0d want %0d", i + 1, obs_ones[i+1], int'(win[W*i +: W]));
            end
        end
        vectors++; if (obs_clr != 1 || !obs_clr_first) begin miscompares++; $display("[TB] FAIL basic_dp_clr: %0d cycles, first=%b, want 1 cycle in cycle 1", obs_clr, obs_clr_first); end
        vectors++; if (obs_bad != 0) begin miscompares++; $display("[TB] FAIL basic_sc_x_idle: %0d non-RUN cycles with sc_x!=0, want 0", obs_bad); end
        vectors++; if (obs_busy_low != 0) begin miscompares++; $display("[TB] FAIL basic_busy: low for %0d job cycles, want 0", obs_busy_low); end
        handshake();
        vectors++; if (cur_res_valid !== 1'b0 || cur_px_ready !== 1'b1 || cur_busy !== 1'b0) begin
            miscompares++; $display("[TB] FAIL basic_after_hs: res_valid %b px_ready %b busy %b want 0/1/0", cur_res_valid, cur_px_ready, cur_busy);
        end
    endtask

    task automatic test_pipe_delay();
        sel = 1'b1;
        @(negedge clk);
        start_job(make_window(8'd255), 1'b0);
        run_to_result();
        vectors++; if (obs_cyc != LEN + 5) begin miscompares++; $display("[TB] FAIL pipe_latency: res_valid seen at edge e0+%0d want e0+%0d", obs_cyc, LEN + 5); end
        vectors++; if (obs_res !== 8'd255) begin miscompares++; $display("[TB] FAIL pipe_res_255: got %0d want 255", obs_res); end
        vectors++; if (obs_bad != 0) begin miscompares++; $display("[TB] FAIL pipe_sc_x_drain: %0d CLR/DRAIN cycles with sc_x!=0, want 0", obs_bad); end
        vectors++; if (obs_ones[1] != 255) begin miscompares++; $display("[TB] FAIL pipe_ones: got %0d want 255", obs_ones[1]); end
        handshake();
        start_job(make_window(8'd0), 1'b0);
        run_to_result();
        vectors++; if (obs_res !== 8'd0 || obs_cyc != LEN + 5) begin miscompares++; $display("[TB] FAIL pipe_res_0: got %0d at e0+%0d want 0 at e0+%0d", obs_res, obs_cyc, LEN + 5); end
        handshake();
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        @(negedge clk);
        start_job(make_window(8'd37), 1'b0);
        run_to_result();
        vectors++; if (obs_res !== 8'd37 || obs_cyc != LEN + 2) begin miscompares++; $display("[TB] FAIL b2b_first: got %0d at e0+%0d want 37 at e0+%0d", obs_res, obs_cyc, LEN + 2); end
        drv_data  = make_window(8'd200);
        drv_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (cur_res_valid !== 1'b1 || cur_res_data !== 8'd37 || cur_px_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b2b_hold[%0d]: res_valid %b res_data %0d px_ready %b want 1/37/0", k, cur_res_valid, cur_res_data, cur_px_ready);
            end
            @(negedge clk);
        end
        drv_ready = 1'b1;
        @(negedge clk);
        drv_ready = 1'b0;
        vectors++; if (cur_res_valid !== 1'b0 || cur_px_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_idle: res_valid %b px_ready %b want 0/1", cur_res_valid, cur_px_ready); end
        @(negedge clk);
        drv_valid = 1'b0;
        vectors++; if (cur_dp_clr !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accept: dp_clr %b want 1 one cycle after handshake", cur_dp_clr); end
        run_to_result();
        vectors++; if (obs_res !== 8'd200 || obs_cyc != LEN + 2) begin miscompares++; $display("[TB] FAIL b2b_second: got %0d at e0+%0d want 200 at e0+%0d", obs_res, obs_cyc, LEN + 2); end
        handshake();
    endtask

    task automatic test_abort();
        sel = 1'b0;
        @(negedge clk);
        start_job(make_window(8'd77), 1'b0);
        for (int c = 1; c < 52; c++) @(negedge clk);
        drv_abort = 1'b1;
        @(negedge clk);
        drv_abort = 1'b0;
        vectors++; if (cur_busy !== 1'b0 || cur_px_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_idle: busy %b px_ready %b want 0/1", cur_busy, cur_px_ready); end
        vectors++; if (cur_sc_x !== '0) begin miscompares++; $display("[TB] FAIL abort_sc_x: got %h want 0", cur_sc_x); end
        for (int k = 0; k < 5; k++) begin
            vectors++; if (cur_res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_no_result[%0d]: res_valid %b want 0", k, cur_res_valid); end
            @(negedge clk);
        end
        start_job(make_window(8'd42), 1'b1);
        vectors++; if (obs_wait != 0 || cur_dp_clr !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_idle_ignored: waited %0d dp_clr %b want 0/1", obs_wait, cur_dp_clr); end
        run_to_result();
        vectors++; if (obs_res !== 8'd42 || obs_cyc != LEN + 2) begin miscompares++; $display("[TB] FAIL abort_next_job: got %0d at e0+%0d want 42 at e0+%0d", obs_res, obs_cyc, LEN + 2); end
        vectors++; if (obs_ones[0] != 127) begin miscompares++; $display("[TB] FAIL abort_reseed_c: got %0d want 127", obs_ones[0]); end
        handshake();
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        @(negedge clk);
        start_job(make_window(8'd150), 1'b0);
        for (int c = 1; c < 102; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (bus0.px_ready !== 1'b1 || busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_ctrl: px_ready %b busy %b want 1/0", bus0.px_ready, busy0); end
        vectors++; if (bus0.res_valid !== 1'b0 || bus0.res_data !== 8'd0 || dp_clr0 !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rstmid_out: res_valid %b res_data %0d dp_clr %b want 0/0/0", bus0.res_valid, bus0.res_data, dp_clr0);
        end
        vectors++; if (sc_x0 !== '0) begin miscompares++; $display("[TB] FAIL rstmid_sc_x: got %h want 0", sc_x0); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (cur_px_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_ready: px_ready %b want 1", cur_px_ready); end
        start_job(make_window(8'd9), 1'b0);
        run_to_result();
        vectors++; if (obs_res !== 8'd9 || obs_cyc != LEN + 2) begin miscompares++; $display("[TB] FAIL rstmid_job: got %0d at e0+%0d want 9 at e0+%0d", obs_res, obs_cyc, LEN + 2); end
        handshake();
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        drv_abort = 1'b0;
        drv_data  = '0;
        test_reset();
        test_basic_stream();
        test_pipe_delay();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
